// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronizes eight external lines plus a fault source,
// keeps PEND/MASK/EDGE registers and runs the IDLE/REQ/SERVICE handshake with the CPU.
module irq_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] irq_src,
    input  logic       fault,
    input  logic       ack,
    input  logic       iret,
    input  logic       reg_we,
    input  logic [1:0] reg_sel,
    input  logic [7:0] reg_wdata,
    output logic [7:0] reg_rdata,
    output logic       irq_req,
    output logic [7:0] irq_vec,
    output logic [2:0] cause
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0][7:0] sync_q;
    logic [7:0] sync, sync_prev, rise;
    logic [7:0] pend, pend_nxt, mask, edge_q, edge_type;
    logic [7:0] active, set_ev, w1c, take_clr;
    logic [2:0] top_idx;
    logic       take;

    // sync_q[0] is the newest sample; the last stage feeds everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            sync_prev <= '0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], irq_src};
            sync_prev <= sync;
        end
    end

    assign sync   = sync_q[SYNC_STAGES-1];
    assign rise   = sync & ~sync_prev;
    assign active = pend & mask;
    assign irq_vec = active;

    always_comb begin
        top_idx = '0;
        for (int i = 7; i >= 0; i--)
            if (active[i]) top_idx = 3'(i);
    end

    assign take      = (state == REQ) && ack && (active != 8'h00);
    assign edge_type = edge_q | 8'h01;
    assign set_ev    = rise | {7'b0, fault};
    assign w1c       = (reg_we && reg_sel == 2'd0) ? reg_wdata : 8'h00;
    assign take_clr  = take ? (8'h01 << top_idx) : 8'h00;

    // Set events beat clears on edge bits; level bits just mirror the line.
    assign pend_nxt = (edge_type & (set_ev | (pend & ~(w1c | take_clr))))
                    | (~edge_type & sync);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend   <= 8'h00;
            mask   <= 8'h01;
            edge_q <= 8'hFF;
            cause  <= 3'd0;
        end else begin
            pend <= pend_nxt;
            if (reg_we && reg_sel == 2'd1) mask   <= reg_wdata;
            if (reg_we && reg_sel == 2'd2) edge_q <= reg_wdata;
            if (take) cause <= top_idx;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (active != 8'h00) state_nxt = REQ;
            REQ: begin
                if (take)                  state_nxt = SERVICE;
                else if (active == 8'h00)  state_nxt = IDLE;
            end
            SERVICE: if (iret) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            irq_req   <= 1'b0;
            reg_rdata <= 8'h00;
        end else begin
            state   <= state_nxt;
            irq_req <= (state_nxt == REQ);
            case (reg_sel)
                2'd0:    reg_rdata <= pend;
                2'd1:    reg_rdata <= mask;
                2'd2:    reg_rdata <= edge_q;
                default: reg_rdata <= {state, 3'b000, cause};
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: a cycle-level behavioural model is compared on
// every negedge, plus hand-computed literal checks at the interesting points.
module tb_irq_ctrl;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] irq_src = '0;
    logic       fault = 1'b0, ack = 1'b0, iret = 1'b0, reg_we = 1'b0;
    logic [1:0] reg_sel = '0;
    logic [7:0] reg_wdata = '0;
    logic [7:0] reg_rdata, irq_vec;
    logic       irq_req;
    logic [2:0] cause;

    int errors = 0;
    int checks = 0;

    irq_ctrl #(.SYNC_STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .irq_src(irq_src), .fault(fault), .ack(ack),
        .iret(iret), .reg_we(reg_we), .reg_sel(reg_sel), .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata), .irq_req(irq_req), .irq_vec(irq_vec), .cause(cause)
    );

    always #5 clk = ~clk;

    // hist[k] is the raw irq_src sample taken k edges ago.
    typedef struct packed {
        logic [3:0][7:0] hist;
        logic [7:0]      pend, mask, edg, rdata;
        logic [1:0]      state;
        logic [2:0]      cause;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r = '0;
        r.mask = 8'h01;
        r.edg  = 8'hFF;
        return r;
    endfunction

    function automatic model_t step(model_t c, logic [7:0] src, logic flt, logic ak,
                                    logic ir, logic we, logic [1:0] sel, logic [7:0] wd);
        model_t n;
        logic [7:0] snc, prv, act;
        int idx;
        bit take, et, se, cl;
        n   = c;
        snc = c.hist[S-1];
        prv = c.hist[S];
        act = c.pend & c.mask;
        idx = -1;
        for (int i = 7; i >= 0; i--) if (act[i]) idx = i;
        take = (c.state == 2'd1) && ak && (idx >= 0);
        for (int i = 0; i < 8; i++) begin
            et = c.edg[i] || (i == 0);
            se = (snc[i] && !prv[i]) || (i == 0 && flt);
            cl = (we && sel == 2'd0 && wd[i]) || (take && idx == i);
            if (!et)     n.pend[i] = snc[i];
            else if (se) n.pend[i] = 1'b1;
            else if (cl) n.pend[i] = 1'b0;
        end
        if (we && sel == 2'd1) n.mask = wd;
        if (we && sel == 2'd2) n.edg  = wd;
        case (sel)
            2'd0:    n.rdata = c.pend;
            2'd1:    n.rdata = c.mask;
            2'd2:    n.rdata = c.edg;
            default: n.rdata = {c.state, 3'b000, c.cause};
        endcase
        case (c.state)
            2'd0: if (act != 0) n.state = 2'd1;
            2'd1: begin
                if (take) begin
                    n.state = 2'd2;
                    n.cause = 3'(idx);
                end else if (act == 0) n.state = 2'd0;
            end
            2'd2: if (ir) n.state = 2'd0;
            default: n.state = 2'd0;
        endcase
        for (int k = 3; k > 0; k--) n.hist[k] = c.hist[k-1];
        n.hist[0] = src;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= model_reset();
        else        m <= step(m, irq_src, fault, ack, iret, reg_we, reg_sel, reg_wdata);
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_cmp();
        chk("model irq_req", {7'b0, irq_req}, {7'b0, m.state == 2'd1});
        chk("model irq_vec", irq_vec, m.pend & m.mask);
        chk("model cause", {5'b0, cause}, {5'b0, m.cause});
        chk("model reg_rdata", reg_rdata, m.rdata);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            if (rst_n) model_cmp();
        end
    endtask

    task automatic wr(input logic [1:0] sel, input logic [7:0] d);
        reg_we = 1'b1; reg_sel = sel; reg_wdata = d;
        tick(1);
        reg_we = 1'b0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1; tick(1); ack = 1'b0;
    endtask

    task automatic pulse_iret();
        iret = 1'b1; tick(1); iret = 1'b0;
    endtask

    initial begin
        tick(3);
        chk("reset irq_req", {7'b0, irq_req}, 8'h00);
        chk("reset irq_vec", irq_vec, 8'h00);
        chk("reset cause", {5'b0, cause}, 8'h00);
        chk("reset rdata", reg_rdata, 8'h00);
        rst_n = 1'b1;
        reg_sel = 2'd1; tick(1); chk("reset MASK", reg_rdata, 8'h01);
        reg_sel = 2'd2; tick(1); chk("reset EDGE", reg_rdata, 8'hFF);

        // fault -> request two cycles later, taken as cause 0
        reg_sel = 2'd3; fault = 1'b1; tick(1); fault = 1'b0;
        chk("fault PEND", irq_vec, 8'h01);
        chk("fault req early", {7'b0, irq_req}, 8'h00);
        tick(1); chk("fault req", {7'b0, irq_req}, 8'h01);
        pulse_ack();
        chk("fault cause", {5'b0, cause}, 8'h00);
        chk("fault cleared", irq_vec, 8'h00);
        tick(1); chk("STATUS service", reg_rdata, 8'h80);
        reg_sel = 2'd0; tick(1); chk("PEND after ack", reg_rdata, 8'h00);
        pulse_iret();

        // two simultaneous edges, priority and re-request
        wr(2'd1, 8'h0C);
        irq_src = 8'h0C;
        tick(3); chk("edge latency early", {7'b0, irq_req}, 8'h00);
        tick(1); chk("edge latency", {7'b0, irq_req}, 8'h01);
        chk("edge vec", irq_vec, 8'h0C);
        pulse_ack();
        chk("prio cause 2", {5'b0, cause}, 8'h02);
        chk("prio PEND left", irq_vec, 8'h08);
        pulse_iret();
        tick(1); chk("re-request", {7'b0, irq_req}, 8'h01);
        pulse_ack();
        chk("prio cause 3", {5'b0, cause}, 8'h03);
        chk("all taken", irq_vec, 8'h00);
        pulse_iret();
        irq_src = 8'h00; tick(3);

        // level-type bit 2
        wr(2'd2, 8'hFB);
        wr(2'd1, 8'h04);
        irq_src = 8'h04;
        tick(4); chk("level req", {7'b0, irq_req}, 8'h01);
        chk("level vec", irq_vec, 8'h04);
        pulse_ack();
        chk("level cause", {5'b0, cause}, 8'h02);
        chk("level ack keeps", irq_vec, 8'h04);
        wr(2'd0, 8'h04);
        chk("level W1C ignored", irq_vec, 8'h04);
        irq_src = 8'h00;
        tick(2); chk("level drop early", irq_vec, 8'h04);
        tick(1); chk("level drop", irq_vec, 8'h00);
        pulse_iret();
        wr(2'd2, 8'hFF);

        // masking while requesting withdraws the request
        irq_src = 8'h04;
        tick(4); chk("mask-off req", {7'b0, irq_req}, 8'h01);
        wr(2'd1, 8'h00);
        chk("mask-off vec", irq_vec, 8'h00);
        tick(1); chk("mask-off drop", {7'b0, irq_req}, 8'h00);
        reg_sel = 2'd0; tick(1); chk("mask-off PEND kept", reg_rdata, 8'h04);
        wr(2'd0, 8'h04);
        irq_src = 8'h00; tick(3);

        // ack collides with a fresh fault
        wr(2'd1, 8'h01);
        fault = 1'b1; tick(1); fault = 1'b0;
        tick(1); chk("collide req", {7'b0, irq_req}, 8'h01);
        ack = 1'b1; fault = 1'b1; tick(1); ack = 1'b0; fault = 1'b0;
        chk("collide cause", {5'b0, cause}, 8'h00);
        chk("collide pend", irq_vec, 8'h01);
        pulse_iret();
        tick(1); chk("collide re-req", {7'b0, irq_req}, 8'h01);
        pulse_ack();
        chk("collide cause 2", {5'b0, cause}, 8'h00);
        chk("collide cleared", irq_vec, 8'h00);
        pulse_iret();

        // async reset while in SERVICE with pending 0x30
        wr(2'd1, 8'h31);
        fault = 1'b1; tick(1); fault = 1'b0;
        tick(1);
        pulse_ack();
        irq_src = 8'h30;
        tick(3);
        chk("svc pend", irq_vec, 8'h30);
        chk("svc no req", {7'b0, irq_req}, 8'h00);
        reg_sel = 2'd3; tick(1); chk("svc STATUS", reg_rdata, 8'h80);
        #2 rst_n = 1'b0;
        #1;
        chk("async irq_req", {7'b0, irq_req}, 8'h00);
        chk("async irq_vec", irq_vec, 8'h00);
        chk("async cause", {5'b0, cause}, 8'h00);
        chk("async rdata", reg_rdata, 8'h00);
        irq_src = 8'h00;
        tick(2);
        rst_n = 1'b1;
        tick(1); chk("post-reset STATUS", reg_rdata, 8'h00);
        chk("post-reset vec", irq_vec, 8'h00);
        reg_sel = 2'd1; tick(1); chk("post-reset MASK", reg_rdata, 8'h01);
        tick(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter SYNC_STAGES, 2, number of synchronizer flops per external source (allowed 2..3).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low.
REQ-004 irq_src  input  8  asynchronous external interrupt lines; bit 0 unused externally, tie 0.
REQ-005 fault  input  1  synchronous one-cycle pulse from CPU protection check; sets pending bit 0.
REQ-006 ack  input  1  synchronous pulse: CPU has taken the interrupt (PC to IJA).
REQ-007 iret  input  1  synchronous pulse: CPU executed interrupt return.
REQ-008 reg_we  input  1  register write strobe.
REQ-009 reg_sel  input  2  register select: 0 PEND, 1 MASK, 2 EDGE, 3 STATUS.
REQ-010 reg_wdata  input  8  write data.
REQ-011 reg_rdata  output  8  registered read data.
REQ-012 irq_req  output  1  interrupt request to CPU.
REQ-013 irq_vec  output  8  masked pending vector (CPU IR image), equal to PEND & MASK.
REQ-014 cause  output  3  index of interrupt currently taken.

Function
REQ-015 Each irq_src bit SHALL pass through SYNC_STAGES flops; sync[i] is the last-stage value.
REQ-016 EDGE[i]=1: PEND[i] SHALL set on the cycle after sync[i] goes 0->1 (prev-sync flop compare).
REQ-017 EDGE[i]=0: PEND[i] SHALL follow sync[i] each cycle; W1C and ack clears have no effect.
REQ-018 fault=1 SHALL set PEND[0] next edge regardless of EDGE[0]; bit 0 always edge-type.
REQ-019 Write to PEND SHALL clear bits written 1 (W1C); same-cycle set event on a bit wins over clear.
REQ-020 Writes to MASK and EDGE SHALL load reg_wdata; writes to STATUS ignored.
REQ-021 reg_rdata SHALL update one cycle after reg_sel presented; STATUS = {state[1:0], 3'b000, cause[2:0]}.
REQ-022 active = PEND & MASK; priority fixed, lowest index highest.
REQ-023 FSM states: IDLE=0, REQ=1, SERVICE=2; state 3 illegal, SHALL return to IDLE.
REQ-024 IDLE: active!=0 -> REQ next cycle; irq_req=0.
REQ-025 REQ: irq_req=1; ack -> SERVICE, latch cause=highest-priority active index, clear PEND[cause] if edge-type.
REQ-026 REQ: active becomes 0 (masked or cleared) without ack -> IDLE, irq_req drops next cycle.
REQ-027 SERVICE: irq_req=0 (no nesting); pending bits keep accumulating; iret -> IDLE.
REQ-028 ack in IDLE/SERVICE and iret in IDLE/REQ SHALL be ignored.
REQ-029 ack clear and new set event on same bit, same cycle: bit SHALL remain pending.
REQ-030 irq_req and state are registered; irq_vec and cause combinational only from registers.
REQ-031 Latency external edge -> irq_req: SYNC_STAGES+2 cycles (sync, PEND set, REQ entry).

Reset
REQ-032 rst_n=0 SHALL immediately clear sync flops, PEND=0, MASK=8'h01, EDGE=8'hFF, state=IDLE, cause=0, reg_rdata=0, irq_req=0.
REQ-033 Reset mid-REQ or mid-SERVICE SHALL abandon the interrupt; no pending bit survives.
REQ-034 First rising clk after rst_n release SHALL sample normally; no spurious edge from reset-low sync chain.

Verification
REQ-035 Reset, fault pulse -> PEND=8'h01, irq_req=1 two cycles later, ack -> cause=0, PEND=0, STATUS=8'h80.
REQ-036 MASK=8'h0C, irq_src[3] and [2] rise same cycle -> irq_req at +4 cycles, ack -> cause=2, PEND=8'h08; iret -> re-request, ack -> cause=3.
REQ-037 EDGE=8'hFB, irq_src[2] held high, MASK=8'h04 -> ack leaves PEND[2]=1; W1C 8'h04 ignored; drop line -> PEND[2]=0 after sync.
REQ-038 In REQ, write MASK=0 -> state IDLE, irq_req=0 next cycle, PEND unchanged.
REQ-039 ack on cycle fault pulses again (PEND[0] taken) -> PEND[0] stays 1, after iret new request with cause=0.
REQ-040 Assert rst_n=0 in SERVICE with PEND=8'h30 -> all outputs at reset values asynchronously, STATUS reads 8'h00.
